// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned MAX_W = 64;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Returned at MAX_W bits; callers cast down to their operand width.
  function automatic logic [MAX_W-1:0] ALL_ONES(input int unsigned w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  function automatic logic [MAX_W-1:0] MIN_NEG(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned n = 32
) (
  input  logic [n:0]   i_rem,
  input  logic         i_dvd_msb,
  input  logic [n-1:0] i_dvs,
  output logic [n:0]   o_rem,
  output logic         o_qbit
);

  logic [n:0] w_shift;
  logic [n:0] w_diff;
  logic       w_unused_rem_msb;

  // The partial remainder stays below the divisor, so its top bit is always clear.
  assign w_unused_rem_msb = i_rem[n];
  assign w_shift          = {i_rem[n-1:0], i_dvd_msb};
  assign w_diff           = w_shift - {1'b0, i_dvs};
  assign o_qbit           = ~w_diff[n];
  assign o_rem            = o_qbit ? w_diff : w_shift;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional DIV_FAST_PATH_EN: divide-by-zero and signed overflow bypass the iterations.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] Quotient,
  output logic [n-1:0] Remainder,
  output logic         div_by_zero,
  output logic         Overflow
);

  localparam int unsigned   CW         = cnt_width(n);
  localparam logic [n-1:0]  C_ALL_ONES = n'(ALL_ONES(n));
  localparam logic [n-1:0]  C_MIN_NEG  = n'(MIN_NEG(n));
  localparam logic [CW-1:0] C_LAST     = CW'(n - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [n:0]    r_rem;
  logic [n-1:0]  r_dvd;
  logic [n-1:0]  r_dvs;
  logic [n-1:0]  r_a;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_b_zero;
  logic          r_ovf;

  logic          w_a_neg;
  logic          w_b_neg;
  logic [n-1:0]  w_a_mag;
  logic [n-1:0]  w_b_mag;
  logic          w_b_zero;
  logic          w_ovf;
  logic [n:0]    w_step_rem;
  logic          w_qbit;
  logic [n-1:0]  w_quo;
  logic [n-1:0]  w_rem;

  assign w_a_neg  = is_signed & A[n-1];
  assign w_b_neg  = is_signed & B[n-1];
  assign w_a_mag  = w_a_neg ? -A : A;
  assign w_b_mag  = w_b_neg ? -B : B;
  assign w_b_zero = (B == '0);
  assign w_ovf    = is_signed & (A == C_MIN_NEG) & (B == C_ALL_ONES);

  div_step #(.n(n)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[n-1]),
    .i_dvs     (r_dvs),
    .o_rem     (w_step_rem),
    .o_qbit    (w_qbit)
  );

  // Sign fix-up of the magnitudes, then the special-case overrides.
  always_comb begin
    w_quo = r_neg_q ? -r_dvd : r_dvd;
    w_rem = r_neg_r ? -r_rem[n-1:0] : r_rem[n-1:0];
    if (r_b_zero) begin
      w_quo = C_ALL_ONES;
      w_rem = r_a;
    end else if (r_ovf) begin
      w_quo = C_MIN_NEG;
      w_rem = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef DIV_FAST_PATH_EN
          w_state_nxt = (w_b_zero | w_ovf) ? FIX : ITER;
`else
          w_state_nxt = ITER;
`endif
        end
      end
      ITER:    if (r_cnt == C_LAST) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; the quotient shifts into r_dvd as the dividend shifts out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_a         <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_b_zero    <= 1'b0;
      r_ovf       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      busy <= (w_state_nxt != IDLE);
      done <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_a      <= A;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_b_zero <= w_b_zero;
            r_ovf    <= w_ovf;
          end
        end
        ITER: begin
          r_rem <= w_step_rem;
          r_dvd <= {r_dvd[n-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          Quotient    <= w_quo;
          Remainder   <= w_rem;
          div_by_zero <= r_b_zero;
          Overflow    <= r_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at n=8.
module tb_seq_divider;

  localparam int unsigned N = 8;
`ifdef DIV_FAST_PATH_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 10;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         div_by_zero;
  logic         Overflow;

  int checks = 0;
  int errors = 0;

  seq_divider #(.n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .div_by_zero (div_by_zero),
    .Overflow    (Overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, optionally re-pulse start mid-flight, and measure cycles to done.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        input int glitch_at, output int lat, output bit busy_ok);
    @(negedge clk);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b; is_signed = ~s;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == glitch_at) begin
        start = 1'b1; A = 8'd50; B = 8'd5; is_signed = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!busy) busy_ok = 1'b0;
  endtask

  task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic s, input int glitch_at, input int exp_lat,
                    input logic [N-1:0] eq, input logic [N-1:0] er,
                    input logic edz, input logic eov);
    int lat;
    bit busy_ok;
    run_op(a, b, s, glitch_at, lat, busy_ok);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy"}, busy_ok, 1);
    chk({tag, " quotient"}, Quotient, eq);
    chk({tag, " remainder"}, Remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, edz);
    chk({tag, " overflow"}, Overflow, eov);
    @(posedge clk); #1;
    chk({tag, " done_clear"}, done, 0);
    chk({tag, " idle"}, busy, 0);
    chk({tag, " q_hold"}, Quotient, eq);
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", Quotient, 0);
    chk("reset remainder", Remainder, 0);
    chk("reset dbz", div_by_zero, 0);
    chk("reset ovf", Overflow, 0);
    rst = 1'b0;

    op("udiv 200/7", 8'd200, 8'd7, 1'b0, 0, 10, 8'd28, 8'd4, 1'b0, 1'b0);
    op("b2b 100/9", 8'd100, 8'd9, 1'b0, 0, 10, 8'd11, 8'd1, 1'b0, 1'b0);
    op("sdiv -7/2", 8'hF9, 8'h02, 1'b1, 0, 10, 8'hFD, 8'hFF, 1'b0, 1'b0);
    op("sdiv 7/-2", 8'h07, 8'hFE, 1'b1, 0, 10, 8'hFD, 8'h01, 1'b0, 1'b0);
    op("udiv0", 8'h55, 8'h00, 1'b0, 0, SPECIAL_LAT, 8'hFF, 8'h55, 1'b1, 1'b0);
    op("sdiv0 neg", 8'hF0, 8'h00, 1'b1, 0, SPECIAL_LAT, 8'hFF, 8'hF0, 1'b1, 1'b0);
    op("sovf", 8'h80, 8'hFF, 1'b1, 0, SPECIAL_LAT, 8'h80, 8'h00, 1'b0, 1'b1);
    op("u 80/FF", 8'h80, 8'hFF, 1'b0, 0, 10, 8'h00, 8'h80, 1'b0, 1'b0);
    op("start ignored", 8'd100, 8'd9, 1'b0, 4, 10, 8'd11, 8'd1, 1'b0, 1'b0);

    // Reset while the iteration counter reads 4.
    @(negedge clk);
    A = 8'd200; B = 8'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst quotient", Quotient, 0);
    chk("midrst remainder", Remainder, 0);
    chk("midrst dbz", div_by_zero, 0);
    chk("midrst ovf", Overflow, 0);
    n_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("midrst no done", n_done, 0);
    op("after rst 200/7", 8'd200, 8'd7, 1'b0, 0, 10, 8'd28, 8'd4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
